// File: rtl/vector_fetch_decode.sv
// vector_fetch_decode: fetches instruction words and decodes them into vector-core fields
// Ports: clock/reset (sync, active-high); start kicks off fetching from START_PC;
//   imem_rd/imem_addr/imem_rdata form a synchronous memory interface (data returns next cycle);
//   sreg_addr/sreg_rdata read the scalar register file combinationally;
//   id_valid/id_stall handshake the decoded fields ID_* and register_mov_data;
//   halted flags that the HALT opcode has been accepted.
// Optional: FETCH_ISSUE_COUNT_EN adds issue_count, a saturating count of accepted issues.
module vector_fetch_decode #(
   parameter int                         IMEM_ADDR_WIDTH = 10,
   parameter logic [4:0]                 HALT_OPCODE     = 5'b11111,
   parameter logic [IMEM_ADDR_WIDTH-1:0] START_PC        = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   output logic                       imem_rd,
   output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]                imem_rdata,
   output logic [4:0]                 sreg_addr,
   input  logic [31:0]                sreg_rdata,
   input  logic                       id_stall,
   output logic                       id_valid,
   output logic [4:0]                 ID_OP,
   output logic [4:0]                 ID_VD,
   output logic [4:0]                 ID_VS,
   output logic [4:0]                 ID_VT,
   output logic [11:0]                ID_SHAMT,
   output logic [15:0]                ID_IMM16,
   output logic [31:0]                register_mov_data,
`ifdef FETCH_ISSUE_COUNT_EN
   output logic [31:0]                issue_count,
`endif
   output logic                       halted
);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, HALTED} state_t;
   state_t                     state_q, state_d;
   logic [IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]                instr_q, instr_d, mov_q, mov_d;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      mov_d   = mov_q;
      case (state_q)
         IDLE:  state_d = start ? FETCH : IDLE;
         FETCH: state_d = LATCH;
         LATCH: begin
            state_d = ISSUE;
            instr_d = imem_rdata;
            mov_d   = sreg_rdata;
            pc_d    = pc_q + {{(IMEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
         end
         ISSUE: state_d = id_stall ? ISSUE : (instr_q[31:27] == HALT_OPCODE ? HALTED : FETCH);
         default: state_d = HALTED;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         instr_q <= '0;
         mov_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         mov_q   <= mov_d;
      end
   end
`ifdef FETCH_ISSUE_COUNT_EN
   logic [31:0] issue_count_q, issue_count_d;
   always_comb issue_count_d = (state_q == ISSUE && !id_stall && issue_count_q != '1) ? issue_count_q + 32'd1 : issue_count_q;
   always_ff @(posedge clock) begin
      if (reset) issue_count_q <= '0;
      else       issue_count_q <= issue_count_d;
   end
   assign issue_count = issue_count_q;
`endif
   assign imem_rd           = state_q == FETCH;
   assign imem_addr         = pc_q;
   assign sreg_addr         = state_q == LATCH ? imem_rdata[21:17] : 5'd0;
   assign id_valid          = state_q == ISSUE;
   assign halted            = state_q == HALTED;
   assign ID_OP             = instr_q[31:27];
   assign ID_VD             = instr_q[26:22];
   assign ID_VS             = instr_q[21:17];
   assign ID_VT             = instr_q[16:12];
   assign ID_SHAMT          = instr_q[11:0];
   assign ID_IMM16          = instr_q[15:0];
   assign register_mov_data = mov_q;
endmodule

// File: tb/tb_vector_fetch_decode.sv
// tb_vector_fetch_decode: scoreboard bench for vector_fetch_decode
module tb_vector_fetch_decode;
   logic        clock = 0, reset = 1, start = 0, id_stall = 0;
   logic        imem_rd, id_valid, halted;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata = '0, sreg_rdata, register_mov_data;
   logic [4:0]  sreg_addr, ID_OP, ID_VD, ID_VS, ID_VT;
   logic [11:0] ID_SHAMT;
   logic [15:0] ID_IMM16;
   logic        start2 = 0, imem_rd2, id_valid2, halted2;
   logic [1:0]  imem_addr2;
   logic [31:0] imem_rdata2 = '0, sreg_rdata2, mov2;
   logic [4:0]  sreg_addr2, op2, vd2, vs2, vt2;
   logic [11:0] shamt2;
   logic [15:0] imm2;
`ifdef FETCH_ISSUE_COUNT_EN
   logic [31:0] issue_count, issue_count2;
`endif
   logic [31:0] imem [1024];
   logic [31:0] imem2 [4];
   logic [31:0] sreg [32];
   int checks = 0, errors = 0;
   typedef struct packed {logic [31:0] word; logic [31:0] mov;} exp_t;
   exp_t q[$];
   exp_t e;

   vector_fetch_decode dut (
      .clock(clock), .reset(reset), .start(start), .imem_rd(imem_rd), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .sreg_addr(sreg_addr), .sreg_rdata(sreg_rdata), .id_stall(id_stall),
      .id_valid(id_valid), .ID_OP(ID_OP), .ID_VD(ID_VD), .ID_VS(ID_VS), .ID_VT(ID_VT),
      .ID_SHAMT(ID_SHAMT), .ID_IMM16(ID_IMM16), .register_mov_data(register_mov_data),
`ifdef FETCH_ISSUE_COUNT_EN
      .issue_count(issue_count),
`endif
      .halted(halted));

   vector_fetch_decode #(.IMEM_ADDR_WIDTH(2)) dut2 (
      .clock(clock), .reset(reset), .start(start2), .imem_rd(imem_rd2), .imem_addr(imem_addr2),
      .imem_rdata(imem_rdata2), .sreg_addr(sreg_addr2), .sreg_rdata(sreg_rdata2), .id_stall(1'b0),
      .id_valid(id_valid2), .ID_OP(op2), .ID_VD(vd2), .ID_VS(vs2), .ID_VT(vt2),
      .ID_SHAMT(shamt2), .ID_IMM16(imm2), .register_mov_data(mov2),
`ifdef FETCH_ISSUE_COUNT_EN
      .issue_count(issue_count2),
`endif
      .halted(halted2));

   always #5 clock = ~clock;
   always @(posedge clock) if (imem_rd) imem_rdata <= imem[imem_addr];
   always @(posedge clock) if (imem_rd2) imem_rdata2 <= imem2[imem_addr2];
   assign sreg_rdata  = sreg[sreg_addr];
   assign sreg_rdata2 = sreg[sreg_addr2];

   function automatic exp_t mk(input logic [31:0] w);
      exp_t x;
      x.word = w;
      x.mov  = sreg[w[21:17]];
      return x;
   endfunction

   task automatic do_reset();
      reset = 1; start = 0; start2 = 0; id_stall = 0;
      repeat (2) @(negedge clock);
      reset = 0;
      q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({id_valid, imem_rd, halted, ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT, ID_IMM16, register_mov_data, sreg_addr} !== '0 || imem_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs valid=%b rd=%b halted=%b op=%h mov=%h sreg_addr=%h addr=%h exp all zero", id_valid, imem_rd, halted, ID_OP, register_mov_data, sreg_addr, imem_addr);
      end
   endtask

   task automatic test_fetch_decode();
      do_reset();
      imem[0] = 32'h0A4C_5123;
      q.push_back(mk(imem[0]));
      start = 1;
      @(negedge clock); start = 0;
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 10'd0) begin errors++; $display("FAIL fetch_strobe rd=%b addr=%h exp 1/0", imem_rd, imem_addr); end
      @(negedge clock);
      checks++;
      if (id_valid !== 1'b0 || sreg_addr !== 5'h06) begin errors++; $display("FAIL latch_cycle valid=%b sreg_addr=%h exp 0/06", id_valid, sreg_addr); end
      @(negedge clock);
      e = q.pop_front();
      checks++;
      if (id_valid !== 1'b1 || ID_OP !== 5'h01 || ID_VD !== 5'h09 || ID_VS !== 5'h06 || ID_VT !== 5'h05 || ID_SHAMT !== 12'h123 || ID_IMM16 !== 16'h5123) begin
         errors++;
         $display("FAIL decode_fields valid=%b op=%h vd=%h vs=%h vt=%h sh=%h imm=%h exp 1 01 09 06 05 123 5123", id_valid, ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT, ID_IMM16);
      end
      checks++;
      if (register_mov_data !== sreg[6] || register_mov_data !== e.mov) begin errors++; $display("FAIL mov_data got=%h exp=%h", register_mov_data, sreg[6]); end
   endtask

   task automatic test_stall();
      logic [31:0] w;
      do_reset();
      imem[0] = 32'h1234_ABCD;
      imem[1] = 32'h0800_0001;
      q.push_back(mk(imem[0]));
      start = 1;
      @(negedge clock); start = 0;
      repeat (2) @(negedge clock);
      e = q.pop_front();
      for (int c = 0; c < 5; c++) begin
         id_stall = c < 4;
         w = {ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT};
         checks++;
         if (id_valid !== 1'b1 || w !== e.word || ID_IMM16 !== e.word[15:0] || register_mov_data !== e.mov || imem_rd !== 1'b0 || imem_addr !== 10'd1) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d valid=%b fields=%h mov=%h rd=%b addr=%h exp 1 %h %h 0 001", c, id_valid, w, register_mov_data, imem_rd, imem_addr, e.word, e.mov);
         end
         @(negedge clock);
      end
      id_stall = 0;
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 10'd1 || id_valid !== 1'b0) begin errors++; $display("FAIL stall_release rd=%b addr=%h valid=%b exp 1 001 0", imem_rd, imem_addr, id_valid); end
   endtask

   task automatic test_halt();
      int issues = 0;
      logic [31:0] w;
      do_reset();
      imem[0] = 32'h1086_3004;
      imem[1] = 32'h114A_5FFF;
      imem[2] = 32'hF800_0000;
      for (int i = 0; i < 3; i++) q.push_back(mk(imem[i]));
      start = 1;
      @(negedge clock); start = 0;
      for (int c = 0; c < 40 && issues < 3; c++) begin
         @(negedge clock);
         if (id_valid) begin
            e = q.pop_front();
            w = {ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT};
            issues++;
            checks++;
            if (w !== e.word || ID_IMM16 !== e.word[15:0] || register_mov_data !== e.mov || halted !== 1'b0) begin
               errors++;
               $display("FAIL halt_issue n=%0d fields=%h mov=%h halted=%b exp %h %h 0", issues, w, register_mov_data, halted, e.word, e.mov);
            end
         end
      end
      checks++;
      if (issues != 3) begin errors++; $display("FAIL halt_issue_count got=%0d exp=3", issues); end
      for (int c = 0; c < 5; c++) begin
         start = c == 1;
         @(negedge clock);
         checks++;
         if (halted !== 1'b1 || id_valid !== 1'b0 || imem_rd !== 1'b0 || ID_OP !== 5'h1F) begin
            errors++;
            $display("FAIL halted_state cyc=%0d halted=%b valid=%b rd=%b op=%h exp 1 0 0 1f", c, halted, id_valid, imem_rd, ID_OP);
         end
      end
      start = 0;
   endtask

   task automatic test_back_to_back();
      int issues = 0, stalls = 0;
      logic [31:0] w;
      do_reset();
      imem[0] = 32'h1111_1111;
      imem[1] = 32'h2A5C_6777;
      imem[2] = 32'h0000_0000;
      imem[3] = 32'h33FE_0ABC;
      imem[4] = 32'hF8C4_2001;
      for (int i = 0; i < 5; i++) q.push_back(mk(imem[i]));
      start = 1;
      @(negedge clock); start = 0;
      for (int c = 0; c < 60 && issues < 5; c++) begin
         @(negedge clock);
         id_stall = 0;
         if (id_valid) begin
            e = q[0];
            w = {ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT};
            checks++;
            if (w !== e.word || ID_IMM16 !== e.word[15:0] || register_mov_data !== e.mov) begin
               errors++;
               $display("FAIL b2b_issue n=%0d fields=%h mov=%h exp %h %h", issues, w, register_mov_data, e.word, e.mov);
            end
            if (issues == 1 && stalls < 2) begin id_stall = 1; stalls++; end
            else begin void'(q.pop_front()); issues++; end
         end
      end
      @(negedge clock);
      id_stall = 0;
      checks++;
      if (issues != 5 || halted !== 1'b1) begin errors++; $display("FAIL b2b_done issues=%0d halted=%b exp 5 1", issues, halted); end
`ifdef FETCH_ISSUE_COUNT_EN
      checks++;
      if (issue_count !== 32'd5) begin errors++; $display("FAIL issue_count got=%0d exp=5", issue_count); end
`endif
   endtask

   task automatic test_wrap();
      int fetches = 0;
      do_reset();
      for (int i = 0; i < 4; i++) imem2[i] = 32'h0842_1000 + i;
      start2 = 1;
      @(negedge clock); start2 = 0;
      for (int c = 0; c < 40 && fetches < 5; c++) begin
         if (imem_rd2) begin
            checks++;
            if (imem_addr2 !== 2'(fetches % 4)) begin errors++; $display("FAIL wrap_addr n=%0d got=%0d exp=%0d", fetches, imem_addr2, fetches % 4); end
            fetches++;
         end
         @(negedge clock);
      end
      checks++;
      if (fetches != 5) begin errors++; $display("FAIL wrap_fetch_count got=%0d exp=5", fetches); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      do_reset();
      imem[0] = 32'h5DEA_DBEE;
      start = 1;
      @(negedge clock); start = 0;
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      reset = 0;
      checks++;
      if ({id_valid, imem_rd, halted, ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT, ID_IMM16, register_mov_data, sreg_addr} !== '0 || imem_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid valid=%b rd=%b op=%h imm=%h mov=%h addr=%h exp all zero", id_valid, imem_rd, ID_OP, ID_IMM16, register_mov_data, imem_addr);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (id_valid !== 1'b0 || imem_rd !== 1'b0) begin errors++; $display("FAIL reset_mid_idle valid=%b rd=%b exp 0 0", id_valid, imem_rd); end
      imem[0] = 32'h2204_6F0F;
      q.push_back(mk(imem[0]));
      start = 1;
      @(negedge clock); start = 0;
      checks++;
      if (imem_rd !== 1'b1 || imem_addr !== 10'd0) begin errors++; $display("FAIL restart_fetch rd=%b addr=%h exp 1 000", imem_rd, imem_addr); end
      repeat (2) @(negedge clock);
      e = q.pop_front();
      w = {ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT};
      checks++;
      if (id_valid !== 1'b1 || w !== e.word || register_mov_data !== e.mov) begin
         errors++;
         $display("FAIL restart_issue valid=%b fields=%h mov=%h exp 1 %h %h", id_valid, w, register_mov_data, e.word, e.mov);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) sreg[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0013_1F07);
      for (int i = 0; i < 1024; i++) imem[i] = 32'h0800_0000;
      test_reset();
      test_fetch_decode();
      test_stall();
      test_halt();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vector_fetch_decode.md
Name: vector_fetch_decode

Overview:
- Instruction fetch/decode stage directly upstream of the vector processor core.
- Fetches 32-bit words from a synchronous instruction memory and splits them into the decoded fields the core consumes: ID_OP, ID_VD, ID_VS, ID_VT, ID_SHAMT, ID_IMM16 and register_mov_data.
- Presents each decoded instruction for exactly one accepted cycle.
- Honours a downstream stall and stops on a HALT opcode.

Parameters:
- IMEM_ADDR_WIDTH, 10: instruction memory word-address width; PC width.
- HALT_OPCODE, 5'b11111: opcode that stops fetching.
- START_PC, 0: PC value loaded on reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins fetching from START_PC when in IDLE.
- imem_rd  output  1  instruction memory read strobe.
- imem_addr  output  IMEM_ADDR_WIDTH  word address (PC).
- imem_rdata  input  32  instruction word, valid the cycle after imem_rd.
- sreg_addr  output  5  scalar register file read index (asynchronous-read file).
- sreg_rdata  input  32  scalar register value.
- id_stall  input  1  downstream not ready; holds the current issue.
- id_valid  output  1  decoded fields valid this cycle.
- ID_OP  output  5  instruction bits [31:27].
- ID_VD  output  5  bits [26:22].
- ID_VS  output  5  bits [21:17].
- ID_VT  output  5  bits [16:12].
- ID_SHAMT  output  12  bits [11:0].
- ID_IMM16  output  16  bits [15:0].
- register_mov_data  output  32  sreg_rdata captured for this instruction.
- halted  output  1  HALT opcode has been issued.

Behaviour:
- Reset:
  - State IDLE, PC=START_PC.
  - All outputs 0: id_valid, imem_rd, halted, all ID_* fields, register_mov_data, sreg_addr.
  - imem_addr=START_PC.
  - Reset mid-operation aborts any in-flight fetch; a returning imem_rdata is ignored.
- FSM states: IDLE, FETCH, LATCH, ISSUE, HALTED.
- IDLE:
  - imem_rd=0.
  - start=1 -> FETCH.
  - start outside IDLE is ignored.
- FETCH (1 cycle):
  - imem_rd=1, imem_addr=PC.
  - -> LATCH.
- LATCH (1 cycle):
  - imem_rdata is valid.
  - sreg_addr=imem_rdata[21:17], combinational.
  - At the clock edge, capture all field registers from imem_rdata and register_mov_data<=sreg_rdata.
  - PC<=PC+1, wrapping modulo 2^IMEM_ADDR_WIDTH (all-ones -> 0).
  - -> ISSUE.
- ISSUE:
  - id_valid=1; fields stable.
  - id_stall=1: remain in ISSUE with fields and id_valid held; no new fetch.
  - id_stall=0 and ID_OP==HALT_OPCODE: -> HALTED.
  - id_stall=0 otherwise: -> FETCH.
  - The instruction counts as accepted in the cycle with id_valid=1 and id_stall=0.
- HALTED:
  - halted=1, id_valid=0, imem_rd=0.
  - Fields retain the HALT instruction.
  - Only reset exits; start is ignored.
- Timing:
  - Throughput: one instruction per 3 cycles without stalls.
  - Latency from start to first id_valid: 3 cycles (FETCH, LATCH, ISSUE).
- id_stall outside ISSUE has no effect.
- Opcode 0 (NOP) is issued like any other instruction; this stage does no opcode filtering except HALT.

Optional Feature:
- Macro: FETCH_ISSUE_COUNT_EN.
- Defined:
  - Adds output port issue_count [31:0]: number of accepted issues, HALT included.
  - Resets to 0 on reset.
  - Increments once per accepted issue (id_valid & ~id_stall).
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Fetch/decode: imem[0]=32'h0A4C_5123, start pulse -> id_valid at cycle 3 with ID_OP=5'h01, ID_VD=5'h09, ID_VS=5'h06, ID_VT=5'h05, ID_SHAMT=12'h123, ID_IMM16=16'h5123; register_mov_data equals sreg[6].
- Stall: hold id_stall=1 for 4 cycles during ISSUE -> id_valid and fields constant for 5 cycles; imem_rd stays 0; PC=1 until release.
- Halt: imem[0..2] = two adds, then an instruction with OP=5'b11111 -> three issues, halted=1 after the third accepted issue, imem_rd remains 0 thereafter, start ignored.
- Wrap: IMEM_ADDR_WIDTH=2, four non-halt words -> fifth fetch has imem_addr=0.
- Reset mid-fetch: assert reset in LATCH -> next cycle IDLE with all outputs 0; a new start fetches from address 0.
- FETCH_ISSUE_COUNT_EN defined: 5 issues ending in HALT with 2 stall cycles -> issue_count=5.
